// File: rtl/debug_uart_tx_if.sv
// Data-bus port of the debug UART: chip-enable, write strobe,
// one address bit, write data and combinational read data.
interface debug_uart_tx_if;
  logic        ce_i;
  logic        we_i;
  logic        addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output ce_i, we_i, addr_i, data_i,
    input  data_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, data_i,
    output data_o
  );
endinterface

// File: rtl/debug_uart_tx.sv
// Memory-mapped debug UART transmitter: byte FIFO feeding an
// 8N1 serializer, with a STATUS register and idle interrupt.
module debug_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  debug_uart_tx_if.slave   bus,
  output logic             tx_o,
  output logic             irq_o
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int BW   = $clog2(CLK_DIV);
  localparam logic [BW-1:0] RELOAD = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_n;
  logic [BW-1:0] cnt_q, cnt_n;
  logic [2:0]    bit_q, bit_n;
  logic [7:0]    shift_q, shift_n;
  logic          tx_n;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_n;
  logic          ovf_q;

  logic full, empty, push, wr_ok, clr, pop;
  logic unused_bits;

  assign unused_bits = ^bus.data_i[31:8];

  assign full  = count_q == CW'(FIFO_DEPTH);
  assign empty = count_q == '0;
  assign push  = bus.ce_i & bus.we_i & ~bus.addr_i;
  assign clr   = bus.ce_i & bus.we_i & bus.addr_i;
  // Full is judged on the pre-edge count, so a same-edge pop
  // never makes room for a push.
  assign wr_ok = push & ~full;
  assign pop   = (state_q == IDLE) & ~empty;

  always_comb begin
    count_n = count_q;
    if (wr_ok & ~pop)
      count_n = count_q + CW'(1);
    else if (pop & ~wr_ok)
      count_n = count_q - CW'(1);
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    tx_n    = tx_o;
    unique case (state_q)
      IDLE: begin
        tx_n = 1'b1;
        if (pop) begin
          shift_n = mem[head_q];
          cnt_n   = RELOAD;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_n   = RELOAD;
          tx_n    = shift_q[0];
          bit_n   = 3'd0;
          state_n = DATA;
        end else begin
          cnt_n = cnt_q - BW'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_n = RELOAD;
          if (bit_q == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n = shift_q >> 1;
            tx_n    = shift_q[1];
            bit_n   = bit_q + 3'd1;
          end
        end else begin
          cnt_n = cnt_q - BW'(1);
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (cnt_q == '0)
          state_n = IDLE;
        else
          cnt_n = cnt_q - BW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_o    <= 1'b1;
      irq_o   <= 1'b1;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      tx_o    <= tx_n;
      irq_o   <= (count_n == '0) & (state_n == IDLE);
      count_q <= count_n;
      if (wr_ok)
        tail_q <= tail_q + AW'(1);
      if (pop)
        head_q <= head_q + AW'(1);
      if (push & full)
        ovf_q <= 1'b1;
      else if (clr)
        ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[tail_q] <= bus.data_i[7:0];
  end

  always_comb begin
    bus.data_o = '0;
    if (bus.ce_i & bus.addr_i)
      bus.data_o = {28'd0, ovf_q, state_q != IDLE, empty, full};
  end
endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx: a line receiver decodes
// frames while stimulus tasks poke the bus and STATUS.
module tb_debug_uart_tx;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx, irq;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0] rx_q[$];
  int         rx_t[$];

  debug_uart_tx_if bus();

  debug_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .tx_o (tx),
    .irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(logic a, logic [31:0] d);
    bus.ce_i   = 1'b1;
    bus.we_i   = 1'b1;
    bus.addr_i = a;
    bus.data_i = d;
    @(posedge clk);
    #1;
    bus.ce_i   = 1'b0;
    bus.we_i   = 1'b0;
    bus.addr_i = 1'b0;
    bus.data_i = '0;
  endtask

  task automatic read_status(output logic [31:0] v);
    bus.ce_i   = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = 1'b1;
    #1;
    v = bus.data_o;
    bus.ce_i   = 1'b0;
    bus.addr_i = 1'b0;
  endtask

  task automatic wait_frames(int n, int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("frame_count", rx_q.size(), n);
  endtask

  // Receiver: samples mid-bit, drops any frame touched by reset.
  initial begin
    int t;
    logic ab, st, sp;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst && !tx) begin
        t  = cyc;
        ab = 1'b0;
        b  = '0;
        for (int w = 0; w < DIV / 2; w++) begin
          @(negedge clk);
          if (!rst) ab = 1'b1;
        end
        st = tx;
        for (int k = 0; k < 8; k++) begin
          for (int w = 0; w < DIV; w++) begin
            @(negedge clk);
            if (!rst) ab = 1'b1;
          end
          b[k] = tx;
        end
        for (int w = 0; w < DIV; w++) begin
          @(negedge clk);
          if (!rst) ab = 1'b1;
        end
        sp = tx;
        if (!ab) begin
          check("start_bit", st, 0);
          check("stop_bit", sp, 1);
          rx_q.push_back(b);
          rx_t.push_back(t);
        end
      end
    end
  end

  initial begin
    logic [31:0] s;
    logic [7:0]  byte_v;
    logic        exp_tx;

    bus.ce_i   = 1'b0;
    bus.we_i   = 1'b0;
    bus.addr_i = 1'b0;
    bus.data_i = '0;

    // Reset and idle state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_irq", irq, 1);
    read_status(s);
    check("rst_status", s, 32'h2);
    bus.ce_i = 1'b1;
    #1;
    check("txdata_read", bus.data_o, 0);
    bus.ce_i = 1'b0;
    bus.addr_i = 1'b1;
    #1;
    check("ce_low_read", bus.data_o, 0);
    bus.addr_i = 1'b0;

    // Single byte with cycle-exact line check
    @(posedge clk);
    #1;
    byte_v = 8'hA5;
    bus_write(1'b0, 32'hFFFF_FFA5);
    check("e0_tx", tx, 1);
    check("e0_irq", irq, 0);
    for (int i = 1; i <= 41; i++) begin
      @(posedge clk);
      #1;
      if (i <= 4)       exp_tx = 1'b0;
      else if (i <= 36) exp_tx = byte_v[(i - 5) / 4];
      else              exp_tx = 1'b1;
      check($sformatf("a5_tx_%0d", i), tx, exp_tx);
      if (i == 1 || i == 40 || i == 41) begin
        read_status(s);
        check($sformatf("a5_busy_%0d", i), s[2], i <= 40);
        check($sformatf("a5_irq_%0d", i), irq, i > 40);
      end
    end
    wait_frames(1, 20);
    check("a5_byte", rx_q[0], 8'hA5);
    rx_q.delete();
    rx_t.delete();

    // Burst of three
    repeat (3) @(posedge clk);
    #1;
    bus_write(1'b0, 32'h41);
    bus_write(1'b0, 32'h42);
    bus_write(1'b0, 32'h43);
    read_status(s);
    check("burst_status", s, 32'h4);
    wait_frames(3, 200);
    check("burst_b0", rx_q[0], 8'h41);
    check("burst_b1", rx_q[1], 8'h42);
    check("burst_b2", rx_q[2], 8'h43);
    check("burst_gap01", rx_t[1] - rx_t[0], 41);
    check("burst_gap12", rx_t[2] - rx_t[1], 41);
    read_status(s);
    check("burst_tail", s, 32'h6);
    repeat (4) @(posedge clk);
    #1;
    read_status(s);
    check("burst_done", s, 32'h2);
    check("burst_irq", irq, 1);
    rx_q.delete();
    rx_t.delete();

    // Overflow: 10 writes, 9 accepted
    for (int i = 0; i < 10; i++)
      bus_write(1'b0, 32'h30 + i);
    read_status(s);
    check("ovf_status", s, 32'hD);
    bus_write(1'b1, 32'h0);
    read_status(s);
    check("ovf_cleared", s, 32'h5);
    wait_frames(9, 9 * 41 + 60);
    for (int i = 0; i < 9; i++)
      check($sformatf("ovf_b%0d", i), rx_q[i], 8'h30 + i);
    repeat (100) @(posedge clk);
    #1;
    check("ovf_no_10th", rx_q.size(), 9);
    check("ovf_irq", irq, 1);
    rx_q.delete();
    rx_t.delete();

    // Pointer wrap-around in groups of five
    for (int g = 0; g < 4; g++) begin
      for (int j = 0; j < 5; j++)
        bus_write(1'b0, g * 5 + j);
      wait_frames(5, 5 * 41 + 60);
      for (int j = 0; j < 5; j++)
        check($sformatf("wrap_b%0d", g * 5 + j), rx_q[j], g * 5 + j);
      repeat (8) @(posedge clk);
      #1;
      rx_q.delete();
      rx_t.delete();
    end

    // Reset in the middle of data bit 3
    bus_write(1'b0, 32'h55);
    bus_write(1'b0, 32'h01);
    bus_write(1'b0, 32'h02);
    repeat (16) @(posedge clk);
    #1;
    check("mid_bit3", tx, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_irq", irq, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    read_status(s);
    check("mid_status", s, 32'h2);
    repeat (150) @(posedge clk);
    #1;
    check("mid_no_frames", rx_q.size(), 0);
    check("mid_idle_tx", tx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/debug_uart_tx.md
Name: debug_uart_tx

Overview:
- Memory-mapped debug output device for the minimal SOPC.
- The CPU writes bytes over the data-bus port. They are buffered in a small FIFO and serialized out on a UART TX line (8N1).
- This gives the SOPC an outbound channel to the bench or the outside world, complementing the clock/reset stimulus driven into it.
- It sits on the data-memory bus alongside data RAM, selected by its own chip-enable.

Parameters:
- CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 8, byte entries in the TX FIFO; power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low (asserted when 0, sampled on clk rising edge).
- ce_i  input  1  device select from the data bus.
- we_i  input  1  write strobe; valid only with ce_i=1.
- addr_i  input  1  register select: 0=TXDATA, 1=STATUS.
- data_i  input  32  write data; TXDATA uses [7:0].
- data_o  output  32  read data, combinational from the addressed register.
- tx_o  output  1  UART serial output, idle high, registered.
- irq_o  output  1  high while FIFO empty and transmitter idle, registered.

Behaviour:
- Reset (rst=0 at an edge):
  - tx_o=1, irq_o=1.
  - FIFO pointers and count = 0, so the FIFO is empty.
  - overflow=0, FSM=IDLE, baud counter=0, shift register=0.
  - Reset mid-frame aborts the frame: tx_o=1 from the next edge, FIFO contents discarded.
- STATUS register, as seen on data_o when addr_i=1:
  - [0] full, [1] empty, [2] busy (FSM!=IDLE), [3] overflow (sticky).
  - [31:4] = 0.
- data_o:
  - Reading addr_i=0 returns 0.
  - data_o = 0 whenever ce_i=0.
- Push: ce_i=1 & we_i=1 & addr_i=0.
  - If not full, data_i[7:0] is written at the tail on that edge; count+1.
  - If full, the write is dropped and overflow<=1.
- Overflow clear: ce_i=1 & we_i=1 & addr_i=1 clears overflow (data ignored).
- Full test: evaluated on the pre-edge count. A push while full is rejected even if a pop occurs on the same edge. A push and a pop on the same edge with 0<count<DEPTH leave count unchanged.
- Pointers: wrap modulo FIFO_DEPTH.
- Count width: log2(FIFO_DEPTH)+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If FIFO non-empty at an edge: pop the head into the shift register, baud counter<=CLK_DIV-1, tx_o<=0, state<=START.
  - START: on each edge, if counter==0 then reload CLK_DIV-1, tx_o<=shift[0], bit index<=0, state<=DATA; else counter-1.
  - DATA: when counter==0:
    - if bit index==7: tx_o<=1, state<=STOP;
    - else shift right, tx_o<=next bit, index+1.
    - Reload the counter in both cases. Bits go out LSB first.
  - STOP: tx_o=1; when counter==0, state<=IDLE.
- Timing:
  - Every bit (start, 8 data, stop) lasts exactly CLK_DIV cycles; a frame is 10*CLK_DIV cycles.
  - Latency: a push accepted at edge E0 drives tx_o low from edge E1, provided the FSM is IDLE.
  - Back-to-back frames: one IDLE cycle between the end of a stop bit and the next start bit, so the frame period is 10*CLK_DIV+1 cycles.
- A push on the same edge that IDLE sees the FIFO empty is not popped until the following edge.
- irq_o <= (next count==0) & (next state==IDLE).

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, release -> tx_o=1, irq_o=1, STATUS read = 0x00000002.
- Single byte, CLK_DIV=4: write 0xA5 to TXDATA at edge E0 -> tx_o low from E1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles. busy=1 from E1 until E1+40. irq_o returns to 1 at E1+40.
- Burst, CLK_DIV=4: write 0x41,0x42,0x43 on consecutive cycles -> three frames with start-bit edges 41 cycles apart. STATUS empty=1 only after the third pop.
- Overflow, DEPTH=8, CLK_DIV=4: write 10 bytes on consecutive cycles -> first pops at next edge, so 9 accepted (1 in shifter + 8 queued) and 10th dropped. overflow=1, STATUS=0x0000000D (full, busy, overflow). Write to STATUS clears overflow -> bit 3 reads 0.
- Wrap-around: push and drain 20 bytes 0x00..0x13 in groups of 5 -> serialized order matches write order; no lost or duplicated bytes across pointer wrap.
- Reset mid-frame: write 0x55 plus 2 more bytes, assert rst=0 during data bit 3 -> tx_o=1 next edge, STATUS=0x00000002 after release, no further frames emitted.
